// File: rtl/amul_pkg.sv
// Shared helpers for the amul_pipe_unsigned approximate multiplier:
// per-row column masks, the compensation constant and parameter legality.
package amul_pkg;

    // Column mask for approximated row 'row': bit j is set when the partial
    // product x[row]&y[j] lands in a kept column (row + j >= trunc_col).
    function automatic logic [31:0] col_mask(input int row, input int w, input int trunc_col);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 32; j++) begin
            if ((j < w) && (row + j >= trunc_col)) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

    // Bias that recentres the truncation error: half of the lowest kept column.
    function automatic logic [63:0] comp_const(input int trunc_col);
        logic [63:0] c;
        c = '0;
        if (trunc_col > 0) begin
            c = 64'd1 << (trunc_col - 1);
        end
        return c;
    endfunction

    // Legal parameter space of the multiplier.
    function automatic bit params_legal(input int w, input int l, input int trunc_col);
        return (w >= 4) && (w <= 32) && (l >= 0) && (l <= w) &&
               (trunc_col >= 0) && (trunc_col <= 2 * w - 1);
    endfunction

endpackage

// File: rtl/amul_pipe_stage.sv
// Generic data + valid register slice with load enable. The valid bit is
// always reset; the data word is cleared on reset only when CLR_DATA is set.
module amul_pipe_stage #(
    parameter int DW       = 8,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          vld_in,
    input  logic [DW-1:0] data_in,
    output logic          vld,
    output logic [DW-1:0] data
);

    // Valid bit follows the upstream valid whenever the slice loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= vld_in;
        end
    end

    if (CLR_DATA) begin : g_data_clr
        // Data word with reset clear, used where the output must read zero.
        always_ff @(posedge clk) begin
            if (rst) begin
                data <= '0;
            end else if (load) begin
                data <= data_in;
            end
        end
    end else begin : g_data_plain
        // Data word without reset; only meaningful while vld is high.
        always_ff @(posedge clk) begin
            if (load) begin
                data <= data_in;
            end
        end
    end

endmodule

// File: rtl/amul_pipe_unsigned.sv
// Pipelined unsigned approximate multiplier with per-transaction exact mode
// and valid/ready streaming, 3-cycle latency, 1 result per cycle.
// Rows x[L-1:0] keep only product columns >= TRUNC_COL in approximate mode.
// Optional build macro AMUL_COMP_EN adds 2^(TRUNC_COL-1) (saturating) to
// approximate results in the final stage.
module amul_pipe_unsigned
    import amul_pkg::*;
#(
    parameter int W         = 8,
    parameter int L         = 6,
    parameter int TRUNC_COL = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           exact,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] z,
    output logic           out_exact
);

    localparam int PW = 2 * W;

    if (!params_legal(W, L, TRUNC_COL)) begin : g_param_check
        $error("amul_pipe_unsigned: illegal W/L/TRUNC_COL combination");
    end

    logic vld_p0, vld_p1, vld_p2;
    logic load_p0, load_p1, load_p2;

    // A stage loads when empty or when its current contents move on.
    assign load_p2  = !vld_p2 || out_ready;
    assign load_p1  = !vld_p1 || load_p2;
    assign load_p0  = !vld_p0 || load_p1;
    assign in_ready = load_p0;

    // ---- S1: register operands and mode ----
    logic [PW:0]  s0_q;
    logic [W-1:0] x_p0, y_p0;
    logic         exact_p0;

    amul_pipe_stage #(.DW(PW + 1), .CLR_DATA(1'b0)) u_stage_s1 (
        .clk     (clk),
        .rst     (rst),
        .load    (load_p0),
        .vld_in  (in_valid),
        .data_in ({exact, y, x}),
        .vld     (vld_p0),
        .data    (s0_q)
    );
    assign {exact_p0, y_p0, x_p0} = s0_q;

    // ---- S2: partial-product rows, high and low sums ----
    logic [PW-1:0] pp_row [W];
    logic [PW-1:0] hi_c, lo_c;

    for (genvar gi = 0; gi < W; gi++) begin : g_row
        logic [W-1:0] y_sel;
        if (gi < L) begin : g_approx
            localparam logic [31:0] ROW_MASK = col_mask(gi, W, TRUNC_COL);
            assign y_sel = exact_p0 ? y_p0 : (y_p0 & ROW_MASK[W-1:0]);
        end else begin : g_exact
            assign y_sel = y_p0;
        end
        assign pp_row[gi] = x_p0[gi] ? ({{W{1'b0}}, y_sel} << gi) : '0;
    end

    // Rows at and above L form hi, the (masked) rows below L form lo.
    always_comb begin
        hi_c = '0;
        lo_c = '0;
        for (int i = 0; i < W; i++) begin
            if (i >= L) begin
                hi_c = hi_c + pp_row[i];
            end else begin
                lo_c = lo_c + pp_row[i];
            end
        end
    end

    logic [2*PW:0] s1_q;
    logic [PW-1:0] hi_p1, lo_p1;
    logic          exact_p1;

    amul_pipe_stage #(.DW(2 * PW + 1), .CLR_DATA(1'b0)) u_stage_s2 (
        .clk     (clk),
        .rst     (rst),
        .load    (load_p1),
        .vld_in  (vld_p0),
        .data_in ({exact_p0, lo_c, hi_c}),
        .vld     (vld_p1),
        .data    (s1_q)
    );
    assign {exact_p1, lo_p1, hi_p1} = s1_q;

    // ---- S3: final add (optionally compensated) ----
    logic [PW-1:0] z_c;

`ifdef AMUL_COMP_EN
    localparam logic [63:0]   COMP64  = comp_const(TRUNC_COL);
    localparam logic [PW-1:0] COMP    = COMP64[PW-1:0];
    localparam bit            COMP_ON = (L > 0) && (TRUNC_COL > 0);

    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PW] ? {PW{1'b1}} : s[PW-1:0];
    endfunction

    // Approximate results get the bias; exact results pass through untouched.
    always_comb begin
        z_c = hi_p1 + lo_p1;
        if (COMP_ON && !exact_p1) begin
            z_c = sat_add(hi_p1 + lo_p1, COMP);
        end
    end
`else
    assign z_c = hi_p1 + lo_p1;
`endif

    logic [PW:0] s2_q;

    amul_pipe_stage #(.DW(PW + 1), .CLR_DATA(1'b1)) u_stage_s3 (
        .clk     (clk),
        .rst     (rst),
        .load    (load_p2),
        .vld_in  (vld_p1),
        .data_in ({exact_p1, z_c}),
        .vld     (vld_p2),
        .data    (s2_q)
    );
    assign {out_exact, z} = s2_q;
    assign out_valid      = vld_p2;

endmodule

// File: tb/tb_amul_pipe_unsigned.sv
// Self-checking bench for amul_pipe_unsigned (W=8, L=6, TRUNC_COL=8) with a
// second L=0 instance that must always produce the exact product.
module tb_amul_pipe_unsigned;

    localparam int TW  = 8;
    localparam int TL  = 6;
    localparam int TTC = 8;
`ifdef AMUL_COMP_EN
    localparam int COMP = 128;
`else
    localparam int COMP = 0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready0;
    logic [7:0]  x, y;
    logic        exact;
    logic        out_valid, out_valid0;
    logic        out_ready;
    logic [15:0] z, z0;
    logic        out_exact, out_exact0;

    int total = 0;
    int bad   = 0;

    amul_pipe_unsigned #(.W(TW), .L(TL), .TRUNC_COL(TTC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .exact(exact), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .out_exact(out_exact)
    );

    amul_pipe_unsigned #(.W(TW), .L(0), .TRUNC_COL(TTC)) dut_l0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .y(y), .exact(exact), .out_valid(out_valid0),
        .out_ready(out_ready), .z(z0), .out_exact(out_exact0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the product formula written directly with integer arithmetic.
    function automatic logic [15:0] model_z(input logic [7:0] a, input logic [7:0] b, input logic e);
        longint acc;
        if (e) return 16'(longint'(a) * longint'(b));
        acc = (longint'(b) * longint'(a >> TL)) << TL;
        for (int i = 0; i < TL; i++)
            for (int j = 0; j < TW; j++)
                if ((i + j >= TTC) && a[i] && b[j]) acc += longint'(1) << (i + j);
`ifdef AMUL_COMP_EN
        if (TL > 0 && TTC > 0) acc += longint'(1) << (TTC - 1);
        if (acc > 65535) acc = 65535;
`endif
        return 16'(acc);
    endfunction

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       e;
    } txn_t;

    txn_t        q[$];
    logic        stall_prev = 1'b0;
    logic [15:0] z_hold;
    logic        ex_hold;

    // Scoreboard: sample handshakes mid-cycle; they complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_z", 64'(z), 64'(z_hold));
                chk("hold_exact", 64'(out_exact), 64'(ex_hold));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    txn_t t;
                    t = q.pop_front();
                    chk("z", 64'(z), 64'(model_z(t.x, t.y, t.e)));
                    chk("out_exact", 64'(out_exact), 64'(t.e));
                    chk("l0_valid", 64'(out_valid0), 64'(1));
                    chk("l0_z", 64'(z0), 64'(longint'(t.x) * longint'(t.y)));
                    chk("l0_exact", 64'(out_exact0), 64'(t.e));
                end
            end
            if (in_valid && in_ready) begin
                txn_t t;
                t.x = x; t.y = y; t.e = exact;
                q.push_back(t);
            end
            stall_prev = out_valid && !out_ready;
            z_hold     = z;
            ex_hold    = out_exact;
        end
    end

    // One transaction into an empty pipe; out_valid must appear on the 3rd edge.
    task automatic single(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                          input logic e, input int zexp);
        x = xa; y = ya; exact = e; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_lat3"}, 64'(out_valid), 64'(1));
        chk({tag, "_z"}, 64'(z), 64'(zexp));
        chk({tag, "_exact"}, 64'(out_exact), 64'(e));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(q.size()), 64'(0));
    endtask

    initial begin
        int acc, first_block, sent;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; exact = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_z", 64'(z), 64'(0));
        chk("rst_out_exact", 64'(out_exact), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // directed products
        single("ff_ff_apx", 8'hFF, 8'hFF, 1'b0, 63552 + COMP);
        single("ff_ff_exa", 8'hFF, 8'hFF, 1'b1, 65025);
        single("3f_ff_apx", 8'h3F, 8'hFF, 1'b0, 14592 + COMP);
        single("40_10_apx", 8'h40, 8'h10, 1'b0, 1024 + COMP);

        // back-to-back stream with a downstream stall on cycles 2..7
        acc = 0; first_block = -1;
        for (int c = 0; c < 60 && acc < 10; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 2 && c <= 7);
            in_valid  = 1'b1;
            x = 8'($urandom); y = 8'($urandom); exact = 1'($urandom);
            #1;
            if (!in_ready && first_block < 0) first_block = acc;
            if (in_ready) acc++;
        end
        chk("stall_accepts_before_block", 64'(first_block), 64'(3));
        chk("stall_all_accepted", 64'(acc), 64'(10));
        @(posedge clk); #1;
        drain("stall_drain");

        // full pipe with both ends accepting: one result per cycle, no bubble
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            x = 8'($urandom); y = 8'($urandom); exact = 1'($urandom);
            #1;
            if (c >= 3) begin
                chk("full_out_valid", 64'(out_valid), 64'(1));
                chk("full_in_ready", 64'(in_ready), 64'(1));
            end
        end

        // one-cycle reset in the middle of the stream
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_z", 64'(z), 64'(0));
        chk("midrst_out_exact", 64'(out_exact), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        repeat (4) @(posedge clk);
        #1 chk("midrst_nothing_in_flight", 64'(out_valid), 64'(0));

        // randomised sweep with random valid/ready and per-transaction mode
        sent = 0;
        for (int c = 0; c < 4000 && sent < 200; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            x = 8'($urandom); y = 8'($urandom); exact = 1'($urandom);
            #1;
            if (in_valid && in_ready) sent++;
        end
        chk("sweep_sent", 64'(sent), 64'(200));
        @(posedge clk); #1;
        drain("sweep_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amul_pipe_unsigned.md
Name: amul_pipe_unsigned

Overview:
- Parametrised, pipelined, unsigned approximate multiplier; next generation of the team's fixed 8x8 "level-L" approximate multipliers.
- Multiplier rows at and above L are summed exactly; rows below L keep only the partial-product bits in columns >= TRUNC_COL.
- Adds a per-transaction exact/approximate mode and a valid/ready streaming interface with 3-cycle latency.
- Sits in datapaths that evaluate the approximate multipliers under streaming load.

Parameters:
- W, 8, operand width in bits; legal range 4..32.
- L, 6, number of low multiplier rows (x[L-1:0]) that are approximated; legal range 0..W.
- TRUNC_COL, 8, lowest product column kept in the approximated rows; legal range 0..2W-1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block can accept operands this cycle.
- x, input, W, multiplier.
- y, input, W, multiplicand.
- exact, input, 1, 1 = exact product for this transaction; 0 = approximate.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- z, output, 2W, product.
- out_exact, output, 1, echo of the exact bit for this result.

Behaviour:
- Arithmetic (approximate mode): z = ((y * x[W-1:L]) << L) + sum over i<L and j<W with i+j >= TRUNC_COL of x[i]&y[j] << (i+j).
- Arithmetic (exact mode): z = x*y, full 2W bits.
- All sums are unsigned in 2W bits. No overflow is possible without compensation.
- L=0 yields an exact multiplier regardless of mode. TRUNC_COL=0 also yields an exact result.
- Pipeline stage S1 registers x, y and exact.
- Pipeline stage S2 forms hi = (y*x[W-1:L])<<L and lo = the masked low-row sum. In exact mode the mask is all ones. Both sums are registered.
- Pipeline stage S3 registers z = hi + lo (+ compensation; see Optional Feature).
- Latency is exactly 3 cycles from an accepted input to out_valid when there is no backpressure. Throughput is 1 result per cycle.
- An input handshake completes on in_valid && in_ready. An output handshake completes on out_valid && out_ready.
- Each stage holds a valid bit. A stage loads when it is empty or when its contents advance in the same cycle.
- in_ready = !v1 || (v1 advances this cycle). This is combinational from out_ready through the stage valids; there is no combinational path from in_valid.
- While out_valid && !out_ready: z and out_exact hold stable. The pipe fills to 3 entries, then in_ready=0.
- A simultaneous accept at the input and the output with a full pipe moves all stages; no bubble is inserted.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- Reset: all valid bits go to 0; z=0; out_exact=0; out_valid=0; in_ready=1 in the first cycle after rst deasserts. In-flight transactions are discarded.
- rst asserted mid-stream overrides all handshakes that cycle.

Optional Feature:
- Macro: AMUL_COMP_EN.
- When defined, approximate-mode results get the constant 2^(TRUNC_COL-1) added in S3, saturating at 2^(2W)-1. This applies only when L>0 and TRUNC_COL>0.
- Exact-mode results are never compensated.
- When undefined, no constant is added and the S3 adder is 2 operands only. Latency is unchanged in both builds.

Decomposition:
- Package amul_pkg holds: the function computing the column mask for row i (given W and TRUNC_COL), the compensation constant function, and the parameter legality checks as elaboration-time assertions.
- One sub-module is natural: amul_pipe_stage, a generic data+valid register slice with load-enable, instantiated 3 times.
- The arithmetic stays in the top module.

Test Plan (W=8, L=6, TRUNC_COL=8, AMUL_COMP_EN undefined unless stated):
- x=0xFF, y=0xFF, exact=0 -> z=63552 (0xF840), out_exact=0, out_valid rises on the 3rd edge after acceptance.
- Same operands, exact=1 -> z=65025. With AMUL_COMP_EN defined and exact=0 -> z=63680.
- x=0x3F, y=0xFF, approximate -> z=14592 (high rows zero). x=0x40, y=0x10, approximate -> z=1024 (exact, since the low rows are zero).
- Stream 10 back-to-back random operands, out_ready=0 for cycles 2..7 -> in_ready falls after 3 accepts; results emerge in order and match the model; z is held stable while stalled.
- Simultaneous accept with a full pipe and out_ready=1 -> one result per cycle, no bubble. A 1-cycle rst mid-stream -> out_valid=0 and z=0 next cycle, and in_ready=1.
- Randomised sweep with exact toggling per transaction, plus a build with L=0 -> z always equals x*y.
